// File: rtl/core_pkg.sv
// Shared core definitions: opcode constants, data width and the bypass-bus layout.
package core_pkg;

   localparam int DATA_W = 32;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   // Bypass bus is {valid, rd, data}: data at the bottom, rd just above it.
   localparam int BYP_RD_LSB = DATA_W;

   function automatic int byp_valid_bit(input int width_reg);
      return DATA_W + width_reg;
   endfunction

endpackage

// File: rtl/prf_2r1w.sv
// Physical register file: two asynchronous read ports, one synchronous write port,
// register 0 hard-wired to zero.
module prf_2r1w #(
   parameter int WIDTH_REG = 7
) (
   input  logic                 i_clk,
   input  logic                 i_we,
   input  logic [WIDTH_REG-1:0] i_waddr,
   input  logic [31:0]          i_wdata,
   input  logic [WIDTH_REG-1:0] i_raddr1,
   input  logic [WIDTH_REG-1:0] i_raddr2,
   output logic [31:0]          o_rdata1,
   output logic [31:0]          o_rdata2
);

   localparam int DEPTH = 2 ** WIDTH_REG;

   logic [31:0] mem [0:DEPTH-1];

   // Entry 0 is never written; the read mux supplies its zero.
   always_ff @(posedge i_clk) begin
      if (i_we && (i_waddr != '0)) begin
         mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata1 = (i_raddr1 == '0) ? 32'd0 : mem[i_raddr1];
   assign o_rdata2 = (i_raddr2 == '0) ? 32'd0 : mem[i_raddr2];

endmodule

// File: rtl/regread.sv
// Register-read stage for the integer ALU: reads the PRF, forwards operands and
// registers the ALU input bundle. Macro REGREAD_WB_BYPASS_EN adds writeback forwarding.
module regread
   import core_pkg::*;
#(
   parameter int WIDTH_REG = 7,
   parameter int WIDTH_BRM = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_valid,
   input  logic [6:0]             i_uop,
   input  logic [9:0]             i_func,
   input  logic [WIDTH_REG-1:0]   i_rd,
   input  logic [WIDTH_REG-1:0]   i_rs1,
   input  logic [WIDTH_REG-1:0]   i_rs2,
   input  logic [31:0]            i_PC,
   input  logic [31:0]            i_imm,
   input  logic                   i_stall,
   input  logic                   i_flush,
   input  logic [32+WIDTH_REG:0]  i_bypass,
   input  logic                   i_wb_valid,
   input  logic [WIDTH_REG-1:0]   i_wb_addr,
   input  logic [31:0]            i_wb_data,
   output logic                   o_valid,
   output logic [6:0]             o_uop,
   output logic [9:0]             o_func,
   output logic [WIDTH_REG-1:0]   o_addr,
   output logic [31:0]            o_PC,
   output logic [31:0]            o_op1,
   output logic [31:0]            o_op2,
   output logic [31:0]            o_imm
);

   localparam int BYP_V = byp_valid_bit(WIDTH_REG);

   // The branch mask travels with the uop elsewhere; nothing here consumes it.
   logic [WIDTH_BRM-1:0] unused_brm;
   assign unused_brm = '0;

   logic [31:0] rf_rs1;
   logic [31:0] rf_rs2;
   logic        wb_hit1;
   logic        wb_hit2;
   logic [31:0] op1_n;
   logic [31:0] rs2_n;
   logic [31:0] op2_n;
   logic [9:0]  func_n;

   prf_2r1w #(.WIDTH_REG(WIDTH_REG)) u_prf (
      .i_clk    (i_clk),
      .i_we     (i_wb_valid),
      .i_waddr  (i_wb_addr),
      .i_wdata  (i_wb_data),
      .i_raddr1 (i_rs1),
      .i_raddr2 (i_rs2),
      .o_rdata1 (rf_rs1),
      .o_rdata2 (rf_rs2)
   );

`ifdef REGREAD_WB_BYPASS_EN
   assign wb_hit1 = i_wb_valid && (i_wb_addr == i_rs1);
   assign wb_hit2 = i_wb_valid && (i_wb_addr == i_rs2);
`else
   // Without the comparator a same-cycle write is seen only from the next cycle.
   assign wb_hit1 = 1'b0;
   assign wb_hit2 = 1'b0;
`endif

   // Operand priority: p0, then ALU bypass, then writeback, then the file.
   function automatic logic [31:0] resolve(
      input logic [WIDTH_REG-1:0] rs,
      input logic [32+WIDTH_REG:0] byp,
      input logic                 wb_hit,
      input logic [31:0]          wb_data,
      input logic [31:0]          rf_data
   );
      if (rs == '0) begin
         return 32'd0;
      end else if (byp[BYP_V] && (byp[BYP_RD_LSB +: WIDTH_REG] == rs)) begin
         return byp[DATA_W-1:0];
      end else if (wb_hit) begin
         return wb_data;
      end
      return rf_data;
   endfunction

   assign op1_n = resolve(i_rs1, i_bypass, wb_hit1, i_wb_data, rf_rs1);
   assign rs2_n = resolve(i_rs2, i_bypass, wb_hit2, i_wb_data, rf_rs2);

   always_comb begin
      op2_n  = 32'd0;
      func_n = i_func;
      case (i_uop)
         OPC_OP_IMM: begin
            op2_n = i_imm;
            // Only the shifts use funct7 on OP-IMM; elsewhere those bits are immediate.
            if ((i_func[2:0] != 3'b001) && (i_func[2:0] != 3'b101)) begin
               func_n = {7'd0, i_func[2:0]};
            end
         end
         OPC_OP:    op2_n = rs2_n;
         default:   op2_n = 32'd0;
      endcase
   end

   // Handshake: an uop is accepted on an edge where i_valid=1 and i_stall=0; the
   // bundle is then held at the outputs and the ALU consumes it on the following
   // edge. i_stall freezes everything, i_flush clears o_valid only.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         o_uop   <= '0;
         o_func  <= '0;
         o_addr  <= '0;
         o_PC    <= '0;
         o_op1   <= '0;
         o_op2   <= '0;
         o_imm   <= '0;
      end else if (i_flush) begin
         o_valid <= 1'b0;
      end else if (!i_stall) begin
         o_valid <= i_valid;
         if (i_valid) begin
            o_uop  <= i_uop;
            o_func <= func_n;
            o_addr <= i_rd;
            o_PC   <= i_PC;
            o_op1  <= op1_n;
            o_op2  <= op2_n;
            o_imm  <= i_imm;
         end
      end
   end

endmodule

// File: tb/tb_regread.sv
// Self-checking bench for regread: scoreboard of expected bundles plus directed checks.
module tb_regread;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic [6:0]  uop;
   logic [9:0]  func;
   logic [6:0]  rd, rs1, rs2;
   logic [31:0] pc, imm;
   logic        stall, flush;
   logic [39:0] bypass;
   logic        wb_valid;
   logic [6:0]  wb_addr;
   logic [31:0] wb_data;
   logic        o_valid;
   logic [6:0]  o_uop;
   logic [9:0]  o_func;
   logic [6:0]  o_addr;
   logic [31:0] o_pc, o_op1, o_op2, o_imm;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0]  mdl_rf [0:127];
   logic [151:0] exp_q [$];
   logic [151:0] last_exp;
   logic [151:0] mon_exp;
   logic         mon_take;
   wire  [151:0] act = {o_uop, o_func, o_addr, o_pc, o_op1, o_op2, o_imm};

   always #5 clk = ~clk;

   regread dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_valid    (valid),
      .i_uop      (uop),
      .i_func     (func),
      .i_rd       (rd),
      .i_rs1      (rs1),
      .i_rs2      (rs2),
      .i_PC       (pc),
      .i_imm      (imm),
      .i_stall    (stall),
      .i_flush    (flush),
      .i_bypass   (bypass),
      .i_wb_valid (wb_valid),
      .i_wb_addr  (wb_addr),
      .i_wb_data  (wb_data),
      .o_valid    (o_valid),
      .o_uop      (o_uop),
      .o_func     (o_func),
      .o_addr     (o_addr),
      .o_PC       (o_pc),
      .o_op1      (o_op1),
      .o_op2      (o_op2),
      .o_imm      (o_imm)
   );

   // Scoreboard: every accepted uop must show up after the edge that sampled it.
   always @(posedge clk) begin
      mon_take = rst_n && valid && !stall && !flush;
      #1;
      if (mon_take) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard: bundle accepted with no expected entry");
         end else begin
            mon_exp = exp_q.pop_front();
            if (o_valid !== 1'b1 || act !== mon_exp) begin
               miscompares++;
               $display("FAIL scoreboard: valid=%b got %h want %h", o_valid, act, mon_exp);
            end
         end
      end
   end

   function automatic logic [31:0] exp_operand(input logic [6:0] rs);
      if (rs == 7'd0) return 32'd0;
      if (bypass[39] && bypass[38:32] == rs) return bypass[31:0];
`ifdef REGREAD_WB_BYPASS_EN
      if (wb_valid && wb_addr == rs) return wb_data;
`endif
      return mdl_rf[rs];
   endfunction

   task automatic cycle();
      @(posedge clk);
      if (wb_valid && wb_addr != 7'd0) mdl_rf[wb_addr] = wb_data;
      #1;
   endtask

   task automatic idle();
      valid = 1'b0; stall = 1'b0; flush = 1'b0;
      bypass = '0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
   endtask

   task automatic write_reg(input logic [6:0] a, input logic [31:0] d);
      idle();
      wb_valid = 1'b1; wb_addr = a; wb_data = d;
      cycle();
      idle();
   endtask

   // Drives one uop; bypass/writeback inputs must already be set by the caller.
   task automatic issue(input logic [6:0] u, input logic [9:0] f, input logic [6:0] d,
                        input logic [6:0] s1, input logic [6:0] s2,
                        input logic [31:0] p, input logic [31:0] im);
      logic [31:0] e2;
      logic [9:0]  ef;
      e2 = 32'd0;
      ef = f;
      if (u == OP_IMM) begin
         e2 = im;
         if (f[2:0] != 3'b001 && f[2:0] != 3'b101) ef = {7'd0, f[2:0]};
      end else if (u == OP) begin
         e2 = exp_operand(s2);
      end
      valid = 1'b1; stall = 1'b0; flush = 1'b0;
      uop = u; func = f; rd = d; rs1 = s1; rs2 = s2; pc = p; imm = im;
      last_exp = {u, ef, d, p, exp_operand(s1), e2, im};
      exp_q.push_back(last_exp);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      uop = '0; func = '0; rd = '0; rs1 = '0; rs2 = '0; pc = '0; imm = '0;
      for (int i = 0; i < 128; i++) mdl_rf[i] = 32'd0;
      #12;
      vectors++;
      if (o_valid !== 1'b0 || act !== 152'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: valid=%b bundle=%h want 0", o_valid, act);
      end
      rst_n = 1'b1;
      cycle();
      for (int i = 1; i < 128; i++) write_reg(7'(i), $urandom);
   endtask

   task automatic test_write_read();
      write_reg(7'd5, 32'h1234);
      cycle();
      cycle();
      issue(OP, 10'd0, 7'd10, 7'd5, 7'd0, 32'h100, 32'd0);
      cycle();
      idle();
      vectors++;
      if (o_valid !== 1'b1 || o_op1 !== 32'h1234 || o_op2 !== 32'd0) begin
         miscompares++;
         $display("FAIL write_read: valid=%b op1=%h op2=%h want 1 1234 0", o_valid, o_op1, o_op2);
      end
   endtask

   task automatic test_bypass();
      write_reg(7'd9, 32'd0);
      cycle();
      bypass = {1'b1, 7'd9, 32'hDEAD_BEEF};
      issue(OP, 10'd0, 7'd11, 7'd9, 7'd0, 32'h104, 32'd0);
      cycle();
      vectors++;
      if (o_op1 !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL bypass: op1=%h want deadbeef", o_op1);
      end
      bypass = {1'b1, 7'd9, 32'hDEAD_BEEF};
      wb_valid = 1'b1; wb_addr = 7'd9; wb_data = 32'h1111;
      issue(OP, 10'd0, 7'd12, 7'd9, 7'd0, 32'h108, 32'd0);
      cycle();
      idle();
      vectors++;
      if (o_op1 !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL bypass_over_wb: op1=%h want deadbeef", o_op1);
      end
   endtask

   task automatic test_wb_forward();
      write_reg(7'd3, 32'hABCD);
      cycle();
      wb_valid = 1'b1; wb_addr = 7'd3; wb_data = 32'd7;
      issue(OP, 10'd0, 7'd13, 7'd0, 7'd3, 32'h10C, 32'd0);
      cycle();
      idle();
      vectors++;
`ifdef REGREAD_WB_BYPASS_EN
      if (o_op2 !== 32'd7) begin
         miscompares++;
         $display("FAIL wb_forward: op2=%h want 7", o_op2);
      end
`else
      if (o_op2 !== 32'hABCD) begin
         miscompares++;
         $display("FAIL wb_same_cycle_old: op2=%h want abcd", o_op2);
      end
`endif
      issue(OP, 10'd0, 7'd14, 7'd0, 7'd3, 32'h110, 32'd0);
      cycle();
      idle();
      vectors++;
      if (o_op2 !== 32'd7) begin
         miscompares++;
         $display("FAIL wb_next_cycle: op2=%h want 7", o_op2);
      end
   endtask

   task automatic test_imm_func();
      issue(OP_IMM, 10'b0100000_000, 7'd15, 7'd1, 7'd2, 32'h200, 32'hFFFF_FFFC);
      cycle();
      vectors++;
      if (o_op2 !== 32'hFFFF_FFFC || o_func !== 10'd0) begin
         miscompares++;
         $display("FAIL addi_norm: op2=%h func=%b want fffffffc 0", o_op2, o_func);
      end
      issue(OP_IMM, 10'b0100000_101, 7'd16, 7'd1, 7'd2, 32'h204, 32'h0000_0403);
      cycle();
      vectors++;
      if (o_func !== 10'b0100000_101) begin
         miscompares++;
         $display("FAIL srai_func: func=%b want 0100000101", o_func);
      end
      issue(LUI, 10'b1111111_111, 7'd17, 7'd4, 7'd5, 32'h208, 32'h1234_5000);
      cycle();
      vectors++;
      if (o_op2 !== 32'd0 || o_func !== 10'b1111111_111) begin
         miscompares++;
         $display("FAIL lui_op2: op2=%h func=%b want 0 1111111111", o_op2, o_func);
      end
      issue(7'b1111111, 10'd0, 7'd18, 7'd4, 7'd5, 32'h20C, 32'hCAFE_0000);
      cycle();
      idle();
      vectors++;
      if (o_op2 !== 32'd0 || o_uop !== 7'b1111111) begin
         miscompares++;
         $display("FAIL unknown_uop: op2=%h uop=%b want 0 1111111", o_op2, o_uop);
      end
   endtask

   task automatic test_stall_flush();
      issue(OP, 10'b0000000_111, 7'd20, 7'd5, 7'd3, 32'h300, 32'h55);
      cycle();
      // A uop offered during the stall must be dropped.
      idle();
      stall = 1'b1; valid = 1'b1;
      uop = OP_IMM; func = 10'h3FF; rd = 7'd99; rs1 = 7'd1; rs2 = 7'd2;
      pc = 32'hBAD0; imm = 32'hBAD1;
      bypass = {1'b1, 7'd5, 32'h9999_9999};
      for (int i = 0; i < 3; i++) begin
         cycle();
         vectors++;
         if (o_valid !== 1'b1 || act !== last_exp) begin
            miscompares++;
            $display("FAIL stall_hold[%0d]: valid=%b got %h want %h", i, o_valid, act, last_exp);
         end
      end
      flush = 1'b1;
      cycle();
      vectors++;
      if (o_valid !== 1'b0 || act !== last_exp) begin
         miscompares++;
         $display("FAIL flush_stall: valid=%b got %h want 0 %h", o_valid, act, last_exp);
      end
      idle();
      cycle();
      vectors++;
      if (o_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_after_flush: valid=%b want 0", o_valid);
      end
   endtask

   task automatic test_p0();
      write_reg(7'd0, 32'hFF);
      cycle();
      issue(OP, 10'd0, 7'd21, 7'd0, 7'd0, 32'h400, 32'd0);
      cycle();
      idle();
      vectors++;
      if (o_op1 !== 32'd0 || o_op2 !== 32'd0) begin
         miscompares++;
         $display("FAIL p0_read: op1=%h op2=%h want 0 0", o_op1, o_op2);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] u;
      for (int n = 0; n < 60; n++) begin
         idle();
         if ($urandom_range(0, 2) == 0) begin
            wb_valid = 1'b1; wb_addr = 7'($urandom_range(0, 15)); wb_data = $urandom;
         end
         if ($urandom_range(0, 2) == 0)
            bypass = {1'b1, 7'($urandom_range(0, 15)), 32'($urandom)};
         case ($urandom_range(0, 9))
            0: begin
               flush = 1'b1;
               cycle();
               vectors++;
               if (o_valid !== 1'b0) begin
                  miscompares++;
                  $display("FAIL rand_flush[%0d]: valid=%b want 0", n, o_valid);
               end
            end
            1: begin
               stall = 1'b1;
               cycle();
            end
            default: begin
               case ($urandom_range(0, 4))
                  0: u = OP_IMM;
                  1: u = LUI;
                  2: u = AUIPC;
                  3: u = 7'($urandom);
                  default: u = OP;
               endcase
               issue(u, 10'($urandom), 7'($urandom), 7'($urandom_range(0, 15)),
                     7'($urandom_range(0, 15)), $urandom, $urandom);
               cycle();
            end
         endcase
      end
      idle();
      cycle();
   endtask

   task automatic test_async_reset();
      issue(OP, 10'd0, 7'd22, 7'd5, 7'd3, 32'h500, 32'h77);
      cycle();
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (o_valid !== 1'b0 || act !== 152'd0) begin
         miscompares++;
         $display("FAIL async_reset: valid=%b bundle=%h want 0", o_valid, act);
      end
      #2;
      rst_n = 1'b1;
      cycle();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_wb_forward();
      test_imm_func();
      test_stall_flush();
      test_p0();
      test_back_to_back();
      test_async_reset();
      cycle();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d entries never produced", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regread.md
# regread

Register-read stage feeding the integer ALU execute unit of the out-of-order core. It accepts one issued micro-op per cycle and reads two physical source registers from an internal 2-read/1-write physical register file. It resolves each operand against the ALU bypass bus and the ALU writeback port, then presents the ALU's input bundle one cycle later. It is also the sole writer of the physical register file, consuming the ALU's registered writeback.

## Interface
- `WIDTH_REG`, 7: physical register address width; file depth 2^WIDTH_REG.
- `WIDTH_BRM`, 4: branch-mask width; carried through, unused here.

Ports:
- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_valid` in 1: issued uop present.
- `i_uop` in 7: opcode.
- `i_func` in 10: {funct7, funct3}.
- `i_rd`, `i_rs1`, `i_rs2` in WIDTH_REG: destination and source physical registers.
- `i_PC`, `i_imm` in 32: PC and immediate.
- `i_stall` in 1: hold output bundle.
- `i_flush` in 1: kill output bundle.
- `i_bypass` in 33+WIDTH_REG: {valid, rd, data[31:0]} from the ALU's combinational result.
- `i_wb_valid` in 1, `i_wb_addr` in WIDTH_REG, `i_wb_data` in 32: ALU registered writeback.
- `o_valid` out 1, `o_uop` out 7, `o_func` out 10, `o_addr` out WIDTH_REG, `o_PC` out 32, `o_op1` out 32, `o_op2` out 32, `o_imm` out 32: bundle to the ALU.

## Operation
- **Register file write.** When `i_wb_valid` is 1 and `i_wb_addr` != 0, the file writes `i_wb_data` on the clock edge. Physical register 0 always reads 0 and is never written.
- **Operand source, rs1.** Checked in priority order:
  1. rs1 == 0 gives 0.
  2. Bypass valid and bypass rd == rs1 gives bypass data.
  3. Writeback hit (only with `REGREAD_WB_BYPASS_EN`) gives `i_wb_data`.
  4. Otherwise the register file value.
- **Operand source, rs2.** Uses the same chain as rs1.
- **op2 selection.**
  - `i_uop` = 0010011 (OP-IMM): op2 = `i_imm`.
  - `i_uop` = 0110011 (OP): op2 = resolved rs2.
  - LUI/AUIPC: op2 = 0.
- **func normalisation.** For OP-IMM with funct3 != 001 and != 101, `o_func[9:3]` is forced to 0. All other cases pass `i_func` unchanged.
- **Unknown uop.** The bundle passes through with `o_op2` = 0.

## Timing
- **Latency.** An uop is sampled at edge N when `i_valid` is 1 and `i_stall` is 0. Its bundle appears after edge N and is consumed by the ALU at edge N+1.
- **Reset.** All outputs are 0 while `i_rst_n` is low, independent of the clock. The register file contents are not reset.
- **Per-edge update, in priority order:**
  1. `i_flush` = 1: `o_valid` becomes 0; data fields hold.
  2. `i_stall` = 1: all outputs hold. Operands are not re-resolved, since physical registers are single-assignment.
  3. Otherwise: `o_valid` takes `i_valid`. Data fields load only when `i_valid` = 1 and hold otherwise.
- **Input while stalled.** The issuer keeps `i_valid` low while `i_stall` is high. An uop presented during a stall is dropped.
- **Simultaneous matches.** Bypass and writeback both hitting the same register: bypass wins. A register file write plus a read of the same address in one cycle resolves per the Configuration section.

## Configuration
- **`REGREAD_WB_BYPASS_EN` defined.**
  - A source equal to `i_wb_addr` while `i_wb_valid` is 1 reads `i_wb_data`.
  - The issuer may issue a consumer two cycles behind its producer.
- **`REGREAD_WB_BYPASS_EN` undefined.**
  - No writeback comparator; a same-cycle read returns the old file value.
  - The issuer must keep three cycles of producer–consumer distance.

## Structure
- **Shared package `core_pkg`:**
  - Opcode constants: OP 0110011, OP_IMM 0010011, LUI 0110111, AUIPC 0010111.
  - Bypass-bus layout: valid at bit 32+WIDTH_REG, rd above data.
  - Data width 32.
- **Sub-module `prf_2r1w`:** parameter WIDTH_REG; asynchronous read; synchronous write; register 0 hard-wired to zero.
- **Bypass mux.** The per-operand priority mux is a function or generate block instantiated twice. It is not a separate module.

## Test plan
1. **Reset, then write and read.** Reset; write p5 = 0x1234 via writeback. Two cycles later issue OP with rs1 = p5, rs2 = p0 → `o_op1` = 0x1234, `o_op2` = 0, `o_valid` = 1 one cycle after issue.
2. **Bypass.** `i_bypass` = {1, p9, 0xDEAD_BEEF} in the same cycle as issue with rs1 = p9, while the file holds 0 → `o_op1` = 0xDEADBEEF. With `i_wb_addr` = p9 also valid carrying 0x1111, the bypass still wins.
3. **Writeback forward.** With the macro on: `i_wb` writes p3 = 7 while issuing rs2 = p3 → `o_op2` = 7. With it off → the old value, and a read the next cycle returns 7.
4. **Immediate and func normalisation.**
   - OP-IMM ADDI, `i_imm` = 0xFFFF_FFFC, `i_func` = 10'b0100000_000 → `o_op2` = 0xFFFFFFFC, `o_func` = 10'b0000000_000.
   - SRAI with the same funct7 → `o_func` unchanged.
5. **Stall and flush.**
   - Stall for 3 cycles → outputs stable.
   - Flush together with stall → `o_valid` = 0 next edge.
   - Write to p0 with data 0xFF, then read p0 → 0.
6. **Asynchronous reset mid-stream.** Assert `i_rst_n` low between edges with `o_valid` = 1 → all outputs 0 immediately, before the next edge.
